arb_mux_nx1: RTL and testbench



---
 rtl/arb_mux_nx1.sv | 75 +++++++
 tb/tb_arb_mux_nx1.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux_nx1.sv
// N:1 arbitrated multiplexor with a registered valid/ready output stage.
// Round-robin by default; define ARB_MUX_FIXED_PRIORITY_EN for lowest-index-wins priority.
module arb_mux_nx1 #(
    parameter int SIZE  = 64,
    parameter int PORTS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PORTS-1:0]         in_valid,
    input  logic [SIZE-1:0]          in_data [PORTS],
    output logic [PORTS-1:0]         in_ready,
    output logic                     out_valid,
    output logic [SIZE-1:0]          out_data,
    output logic [$clog2(PORTS)-1:0] out_port,
    input  logic                     out_ready
);

    localparam int PW = $clog2(PORTS);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    grant_idx;
    logic [PW-1:0]    idx;
    logic             grant_any;
    logic             load;
    logic [PORTS-1:0] grant;

    // Search upward from ptr; the index wraps naturally because PORTS is a power of two.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < PORTS; k++) begin
            idx = ptr + PW'(k);
            if (!grant_any && in_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign load     = !out_valid || out_ready;
    assign in_ready = (load && !reset) ? grant : '0;

    // A new word may replace the one being drained on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= '0;
        end else if (grant_any && load) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_idx];
            out_port  <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ARB_MUX_FIXED_PRIORITY_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_any && load) begin
            ptr <= grant_idx + PW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_arb_mux_nx1.sv
// Self-checking bench for arb_mux_nx1: directed scenarios plus randomized traffic
// compared every cycle against a queue-free behavioural model of the arbiter.
module tb_arb_mux_nx1;

    localparam int PORTS = 8;
    localparam int SIZE  = 8;

    logic                     clk;
    logic                     reset;
    logic [PORTS-1:0]         in_valid;
    logic [SIZE-1:0]          in_data [PORTS];
    logic [PORTS-1:0]         in_ready;
    logic                     out_valid;
    logic [SIZE-1:0]          out_data;
    logic [$clog2(PORTS)-1:0] out_port;
    logic                     out_ready;

    int n_vectors     = 0;
    int n_miscompares = 0;

    arb_mux_nx1 #(.SIZE(SIZE), .PORTS(PORTS)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_port(out_port),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [PORTS-1:0] valid, input logic ready);
        in_valid  = valid;
        out_ready = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the word the sink should be seeing and where the search starts next.
    logic            m_valid;
    logic [SIZE-1:0] m_data;
    int              m_port;
    int              m_ptr;

    function automatic int pick(input logic [PORTS-1:0] v, input int p);
        for (int k = 0; k < PORTS; k++) begin
            if (v[(p + k) % PORTS]) return (p + k) % PORTS;
        end
        return -1;
    endfunction

    always begin
        logic            n_valid;
        logic [SIZE-1:0] n_data;
        int              n_port;
        int              n_ptr;
        logic [PORTS-1:0] exp_ready;
        int              g;
        int              start;
        logic            can_load;

        @(negedge clk);
        exp_ready = '0;
        if (reset) begin
            m_valid = 1'b0; m_data = '0; m_port = 0; m_ptr = 0;
        end
`ifdef ARB_MUX_FIXED_PRIORITY_EN
        start = 0;
`else
        start = m_ptr;
`endif
        can_load = !m_valid || out_ready;
        g = pick(in_valid, start);
        if (!reset && can_load && g >= 0) exp_ready[g] = 1'b1;

        checkOutput("model_in_ready", 64'(in_ready), 64'(exp_ready));
        checkOutput("model_out_valid", 64'(out_valid), 64'(m_valid));
        checkOutput("model_out_data", 64'(out_data), 64'(m_data));
        checkOutput("model_out_port", 64'(out_port), 64'(m_port));

        n_valid = m_valid; n_data = m_data; n_port = m_port; n_ptr = m_ptr;
        if (can_load && g >= 0) begin
            n_valid = 1'b1;
            n_data  = in_data[g];
            n_port  = g;
            n_ptr   = (g + 1) % PORTS;
        end else if (out_ready) begin
            n_valid = 1'b0;
        end

        @(posedge clk or posedge reset);
        if (reset) begin
            m_valid = 1'b0; m_data = '0; m_port = 0; m_ptr = 0;
        end else begin
            m_valid = n_valid; m_data = n_data; m_port = n_port; m_ptr = n_ptr;
        end
    end

    task automatic doReset();
        reset = 1'b1;
        applyStimulus('0, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus('0, 1'b0);
        for (int i = 0; i < PORTS; i++) in_data[i] = SIZE'(i);
        doReset();
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_port", 64'(out_port), 64'd0);

`ifndef ARB_MUX_FIXED_PRIORITY_EN
        // Fairness: all ports valid, one word per cycle in rotating order.
        applyStimulus('1, 1'b1);
        for (int k = 0; k < PORTS + 1; k++) begin
            tick();
            checkOutput("rr_valid", 64'(out_valid), 64'd1);
            checkOutput("rr_data", 64'(out_data), 64'(k % PORTS));
        end

        // Stall a word from port 5, then reset mid-cycle.
        applyStimulus(8'b0010_0000, 1'b1);
        tick();
        applyStimulus(8'b0010_0000, 1'b0);
        repeat (2) tick();
        checkOutput("stall_port", 64'(out_port), 64'd5);
        checkOutput("stall_valid", 64'(out_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_valid", 64'(out_valid), 64'd0);
        checkOutput("async_reset_data", 64'(out_data), 64'd0);
        checkOutput("async_reset_port", 64'(out_port), 64'd0);
        checkOutput("async_reset_ready", 64'(in_ready), 64'd0);
        tick();
        reset = 1'b0;
        applyStimulus(8'b0000_1000, 1'b1);
        tick();
        checkOutput("post_reset_port", 64'(out_port), 64'd3);

        // Sparse requests with wrap from ptr = 6.
        applyStimulus(8'b0010_0000, 1'b1);
        tick();
        applyStimulus(8'b0000_0101, 1'b1);
        tick();
        checkOutput("wrap_first", 64'(out_port), 64'd0);
        tick();
        checkOutput("wrap_second", 64'(out_port), 64'd2);
        applyStimulus('1, 1'b1);
        tick();
        checkOutput("wrap_ptr_after", 64'(out_port), 64'd3);

        // Backpressure holding 0x2A from port 1.
        in_data[1] = 8'h2A;
        applyStimulus(8'b0000_0010, 1'b1);
        tick();
        applyStimulus('1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
            checkOutput("bp_data", 64'(out_data), 64'h2A);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 64'(in_ready), 64'b0000_0100);
        tick();
        checkOutput("bp_release_port", 64'(out_port), 64'd2);
        checkOutput("bp_release_valid", 64'(out_valid), 64'd1);

        // Idle drain: single word from port 4, then nothing.
        applyStimulus(8'b0001_0000, 1'b1);
        tick();
        checkOutput("idle_word", 64'(out_valid), 64'd1);
        applyStimulus('0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("idle_drained", 64'(out_valid), 64'd0);
        end
        applyStimulus('1, 1'b1);
        tick();
        checkOutput("idle_ptr_held", 64'(out_port), 64'd5);
`else
        applyStimulus('1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("fixed_port0", 64'(out_port), 64'd0);
        end
        applyStimulus(8'b1111_1110, 1'b1);
        tick();
        checkOutput("fixed_port1", 64'(out_port), 64'd1);
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < PORTS; i++) in_data[i] = SIZE'($urandom);
            applyStimulus(PORTS'($urandom), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
